// File: rtl/dot_product_seq_if.sv
// -----------------------------------------------------------------------------
// dot_product_seq_if
//
// Bundles every non-clock signal of the dot-product sequencer: the job request
// from the tile scheduler, the operand-buffer read port, the multiplier port
// and the result valid/ready port.
//
// Modports:
//   slave  - the sequencer itself (takes jobs, drives buffers and multiplier)
//   master - the surrounding system (scheduler, buffers, multiplier, consumer)
//
// Signals:
//   start, len, base_a, base_b, bias, abort  job request / cancel
//   busy                                     sequencer not idle
//   rd_en, rd_addr_a, rd_addr_b              read strobe and addresses
//   rd_data_a, rd_data_b                     signed int8 read data (1-cycle)
//   mul_a, mul_b, mul_p                      multiplier operands and product
//   res_valid, res_data, res_ready           result handshake
// -----------------------------------------------------------------------------
interface dot_product_seq_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int ACC_W  = 32
);

  // Job request
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic [ADDR_W-1:0]        base_a;
  logic [ADDR_W-1:0]        base_b;
  logic signed [ACC_W-1:0]  bias;
  logic                     abort;
  logic                     busy;

  // Operand buffers
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr_a;
  logic [ADDR_W-1:0]        rd_addr_b;
  logic signed [7:0]        rd_data_a;
  logic signed [7:0]        rd_data_b;

  // Multiplier
  logic signed [7:0]        mul_a;
  logic signed [7:0]        mul_b;
  logic signed [ACC_W-1:0]  mul_p;

  // Result
  logic                     res_valid;
  logic signed [ACC_W-1:0]  res_data;
  logic                     res_ready;

  modport slave (
    input  start, len, base_a, base_b, bias, abort,
    input  rd_data_a, rd_data_b, mul_p, res_ready,
    output busy, rd_en, rd_addr_a, rd_addr_b,
    output mul_a, mul_b, res_valid, res_data
  );

  modport master (
    output start, len, base_a, base_b, bias, abort,
    output rd_data_a, rd_data_b, mul_p, res_ready,
    input  busy, rd_en, rd_addr_a, rd_addr_b,
    input  mul_a, mul_b, res_valid, res_data
  );

endinterface : dot_product_seq_if

// File: rtl/dot_product_seq.sv
// -----------------------------------------------------------------------------
// dot_product_seq
//
// Computes one signed int8 dot product plus a 32-bit bias per job.
// A job reads len operand pairs from buffers A and B (1-cycle read latency),
// routes each pair to an external registered multiplier (1-cycle latency)
// and accumulates the products, wrapping modulo 2^ACC_W. The result is
// presented on a valid/ready port and held until accepted.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, ACTIVE HIGH despite its name
//   bus    dot_product_seq_if.slave - job request, buffer read port,
//          multiplier port and result handshake
//
// Timing for a job of length N accepted on edge 0 (cycle c follows edge c):
//   cycles 0..N-1   FETCH, one read per cycle at base+i
//   cycle  i+1      read data on mul_a/mul_b (stage v1)
//   cycle  i+2      product on mul_p (stage v2), added on the closing edge
//   cycles N..N+2   DRAIN, waiting for both stages to empty
//   cycle  N+3      DONE, res_valid high until res_ready
// -----------------------------------------------------------------------------
module dot_product_seq #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int ACC_W  = 32
) (
  input logic             clk,
  input logic             rst_n,
  dot_product_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         issue_cnt_q;
  logic [ADDR_W-1:0]        addr_a_q;
  logic [ADDR_W-1:0]        addr_b_q;
  logic                     v1_q;
  logic                     v2_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic in_fetch;
  logic accept;
  logic last_issue;
  logic kill;
  logic handshake;

  assign in_fetch   = (state_q == FETCH);
  // Any start seen in IDLE is taken, including len=0 (goes straight to DONE).
  assign accept     = (state_q == IDLE) && bus.start;
  // The len-th read is the one issued while the counter shows len-1.
  assign last_issue = in_fetch && (issue_cnt_q == (len_q - LEN_ONE));
  // Abort only cancels a job still moving data; a finished result is kept.
  assign kill       = bus.abort && ((state_q == FETCH) || (state_q == DRAIN));
  assign handshake  = (state_q == DONE) && bus.res_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_d unassigned and a latch can never be inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Both stages empty means the last product was added on the
        // previous edge, so the accumulator now holds the final sum.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!v1_q && !v2_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, pipeline valids and accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others (v2 takes the old v1, acc
      // adds the product that v2 qualified in the cycle just ending).
      state_q <= state_d;

      if (accept) begin
        len_q       <= bus.len;
        issue_cnt_q <= '0;
        addr_a_q    <= bus.base_a;
        addr_b_q    <= bus.base_b;
      end else if (in_fetch) begin
        issue_cnt_q <= issue_cnt_q + LEN_ONE;
        // Natural overflow of the ADDR_W-bit counter gives the address wrap.
        addr_a_q    <= addr_a_q + ADDR_ONE;
        addr_b_q    <= addr_b_q + ADDR_ONE;
      end

      // v1: read data is on the buffer outputs; v2: product is on mul_p.
      if (kill) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
      end else begin
        v1_q <= in_fetch;
        v2_q <= v1_q;
      end

      if (accept) begin
        acc_q <= bus.bias;
      end else if (v2_q && !kill) begin
        acc_q <= acc_q + bus.mul_p;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_en     = in_fetch;
  // Addresses are forced to zero outside FETCH so idle buses stay quiet.
  assign bus.rd_addr_a = in_fetch ? addr_a_q : '0;
  assign bus.rd_addr_b = in_fetch ? addr_b_q : '0;

  // Buffer data goes straight to the multiplier; gating with v1 keeps the
  // operands at zero whenever the buffers are not returning job data.
  assign bus.mul_a     = v1_q ? bus.rd_data_a : 8'sd0;
  assign bus.mul_b     = v1_q ? bus.rd_data_b : 8'sd0;

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = (state_q == DONE) ? acc_q : '0;

  // handshake is kept as a named term for readability of the DONE exit;
  // the FSM uses res_ready directly since DONE is already implied there.
  logic unused_ok;
  assign unused_ok = handshake;

endmodule : dot_product_seq

// File: tb/tb_dot_product_seq.sv
// -----------------------------------------------------------------------------
// tb_dot_product_seq
//
// Bench for dot_product_seq. Models the two operand buffers (1-cycle read)
// and the registered multiplier (1-cycle), drives jobs, and compares results
// against a plain arithmetic dot product computed from the buffer contents.
// -----------------------------------------------------------------------------
module tb_dot_product_seq;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;

  logic signed [7:0] mem_a [DEPTH];
  logic signed [7:0] mem_b [DEPTH];
  int q_a[$];
  int q_b[$];

  dot_product_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

  dot_product_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffers: registered read on rd_en.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.rd_data_a <= mem_a[bus.rd_addr_a];
      bus.rd_data_b <= mem_b[bus.rd_addr_b];
    end
  end

  // Registered signed int8 multiplier.
  always @(posedge clk) begin
    bus.mul_p <= ACC_W'(int'(bus.mul_a) * int'(bus.mul_b));
  end

  // Record every read address issued.
  always @(negedge clk) begin
    if (bus.rd_en === 1'b1) begin
      q_a.push_back(int'(bus.rd_addr_a));
      q_b.push_back(int'(bus.rd_addr_b));
    end
  end

  // Reference: bias plus sum of products, 32-bit wrapping arithmetic.
  function automatic logic [31:0] ref_dot(int n, int ba, int bb, logic [31:0] b);
    logic [31:0] s;
    s = b;
    for (int i = 0; i < n; i++) begin
      s = s + 32'(int'(mem_a[(ba + i) % DEPTH]) * int'(mem_b[(bb + i) % DEPTH]));
    end
    return s;
  endfunction

  // Issue a job at the current negedge; returns at the negedge of cycle 0.
  // Request fields are scrambled afterwards to show they were latched.
  task automatic start_job(input int n, input int ba, input int bb, input logic [31:0] b);
    q_a.delete();
    q_b.delete();
    bus.start  = 1'b1;
    bus.len    = LEN_W'(n);
    bus.base_a = ADDR_W'(ba);
    bus.base_b = ADDR_W'(bb);
    bus.bias   = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.len    = LEN_W'($urandom);
    bus.base_a = ADDR_W'($urandom);
    bus.base_b = ADDR_W'($urandom);
    bus.bias   = $urandom;
  endtask

  // Wait (bounded) for res_valid; lat counts cycles after the start edge.
  task automatic wait_result(output int lat, output logic ok);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    ok = (bus.res_valid === 1'b1);
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // Full job with result, latency and read-count comparisons.
  task automatic run_checked(input string name, input int n, input int ba, input int bb,
                             input logic [31:0] b);
    int lat;
    logic ok;
    logic [31:0] exp;
    exp = ref_dot(n, ba, bb, b);
    start_job(n, ba, bb, b);
    wait_result(lat, ok);
    tests_run++;
    if (!ok || bus.res_data !== exp) begin
      tests_failed++;
      $display("FAIL %s result: got %h valid=%b, expected %h", name, bus.res_data, ok, exp);
    end
    tests_run++;
    if (lat !== n + 3) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, n + 3);
    end
    tests_run++;
    if (q_a.size() !== n) begin
      tests_failed++;
      $display("FAIL %s read count: got %0d, expected %0d", name, q_a.size(), n);
    end
    accept_result();
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.busy, bus.rd_en, bus.res_valid} !== 3'b000 || bus.res_data !== '0 ||
        bus.mul_a !== 8'sd0 || bus.mul_b !== 8'sd0 || bus.rd_addr_a !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: busy=%b rd_en=%b valid=%b data=%h, expected all 0",
               bus.busy, bus.rd_en, bus.res_valid, bus.res_data);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic ok;
    for (int i = 0; i < 4; i++) begin
      mem_a[100 + i] = 8'(i + 1);
      mem_b[200 + i] = 8'(i + 5);
    end
    start_job(4, 100, 200, 32'd0);
    wait_result(lat, ok);
    tests_run++;
    if (!ok || bus.res_data !== 32'd70) begin
      tests_failed++;
      $display("FAIL basic result: got %0d, expected 70", bus.res_data);
    end
    tests_run++;
    if (lat !== 7) begin
      tests_failed++;
      $display("FAIL basic latency: got %0d, expected 7", lat);
    end
    tests_run++;
    if (q_a.size() !== 4 || q_a[0] !== 100 || q_a[3] !== 103 || q_b[0] !== 200 || q_b[3] !== 203) begin
      tests_failed++;
      $display("FAIL basic addresses: count=%0d a=%p b=%p, expected 100..103 / 200..203",
               q_a.size(), q_a, q_b);
    end
    accept_result();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.mul_a !== 8'sd0) begin
      tests_failed++;
      $display("FAIL basic idle after handshake: busy=%b valid=%b mul_a=%0d, expected 0",
               bus.busy, bus.res_valid, bus.mul_a);
    end
  endtask

  task automatic test_signs();
    int lat;
    logic ok;
    mem_a[300] = -8'sd128; mem_a[301] = 8'sd0;  mem_a[302] = 8'sd127;
    mem_b[400] = -8'sd128; mem_b[401] = 8'sd55; mem_b[402] = -8'sd1;
    start_job(3, 300, 400, -32'sd10);
    wait_result(lat, ok);
    tests_run++;
    if (!ok || bus.res_data !== 32'sd16247) begin
      tests_failed++;
      $display("FAIL signs result: got %0d, expected 16247", bus.res_data);
    end
    accept_result();
  endtask

  task automatic test_zero_len_backpressure();
    int lat;
    logic ok;
    logic stable;
    start_job(0, 5, 6, 32'h12345678);
    wait_result(lat, ok);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h12345678) stable = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!ok || stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero-len held result: got %h valid=%b stable=%b, expected 12345678 held",
               bus.res_data, bus.res_valid, stable);
    end
    tests_run++;
    if (q_a.size() !== 0) begin
      tests_failed++;
      $display("FAIL zero-len reads: got %0d, expected 0", q_a.size());
    end
    accept_result();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero-len idle: busy=%b valid=%b, expected 0", bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_addr_wrap();
    run_checked("wrap", 4, 1022, 17, $urandom);
    tests_run++;
    if (q_a.size() !== 4 || q_a[0] !== 1022 || q_a[1] !== 1023 || q_a[2] !== 0 || q_a[3] !== 1) begin
      tests_failed++;
      $display("FAIL wrap addresses: got %p, expected 1022 1023 0 1", q_a);
    end
  endtask

  task automatic test_acc_wrap();
    int lat;
    logic ok;
    mem_a[500] = 8'sd127;
    mem_b[600] = 8'sd1;
    start_job(1, 500, 600, 32'h7FFFFFF0);
    wait_result(lat, ok);
    tests_run++;
    if (!ok || bus.res_data !== 32'h8000006F) begin
      tests_failed++;
      $display("FAIL acc wrap result: got %h, expected 8000006f", bus.res_data);
    end
    accept_result();
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_checked("random", int'($urandom_range(1, 20)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ok;
    int ba;
    int bb;
    logic [31:0] b;
    logic [31:0] exp;
    start_job(2, 10, 20, 32'd3);
    wait_result(lat, ok);
    ba = int'($urandom_range(0, DEPTH - 1));
    bb = int'($urandom_range(0, DEPTH - 1));
    b  = $urandom;
    exp = ref_dot(3, ba, bb, b);
    // Handshake and new start in the same cycle: start must be ignored.
    bus.res_ready = 1'b1;
    bus.start  = 1'b1;
    bus.len    = LEN_W'(3);
    bus.base_a = ADDR_W'(ba);
    bus.base_b = ADDR_W'(bb);
    bus.bias   = b;
    @(negedge clk);
    bus.res_ready = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b start on handshake: busy=%b valid=%b, expected 0", bus.busy, bus.res_valid);
    end
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    bus.start = 1'b0;
    wait_result(lat, ok);
    tests_run++;
    if (!ok || bus.res_data !== exp || lat !== 6) begin
      tests_failed++;
      $display("FAIL b2b second job: got %h lat=%0d, expected %h lat=6", bus.res_data, lat, exp);
    end
    accept_result();
  endtask

  task automatic test_abort();
    int lat;
    logic ok;
    logic seen;
    logic [31:0] exp;
    start_job(8, 40, 50, $urandom);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;                // third FETCH cycle
    @(negedge clk);
    bus.abort = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort idle: busy=%b rd_en=%b, expected 0", bus.busy, bus.rd_en);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b0 || q_a.size() !== 3) begin
      tests_failed++;
      $display("FAIL abort no result: activity=%b reads=%0d, expected 0 / 3", seen, q_a.size());
    end
    // abort together with start in IDLE: start wins; abort in DONE ignored.
    exp = ref_dot(2, 70, 80, 32'd99);
    bus.abort = 1'b1;
    start_job(2, 70, 80, 32'd99);
    bus.abort = 1'b0;
    wait_result(lat, ok);
    bus.abort = 1'b1;
    repeat (2) @(negedge clk);
    bus.abort = 1'b0;
    tests_run++;
    if (!ok || bus.res_valid !== 1'b1 || bus.res_data !== exp) begin
      tests_failed++;
      $display("FAIL abort follow-up job: got %h valid=%b, expected %h valid=1",
               bus.res_data, bus.res_valid, exp);
    end
    accept_result();
  endtask

  task automatic test_reset_mid_drain();
    start_job(4, 100, 200, 32'd1);
    repeat (4) @(negedge clk);       // cycle 4: first DRAIN cycle, v1 live
    tests_run++;
    if (bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.mul_a !== 8'sd4) begin
      tests_failed++;
      $display("FAIL drain state: busy=%b rd_en=%b mul_a=%0d, expected 1/0/4",
               bus.busy, bus.rd_en, bus.mul_a);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({bus.busy, bus.rd_en, bus.res_valid} !== 3'b000 || bus.res_data !== '0 ||
        bus.mul_a !== 8'sd0 || bus.mul_b !== 8'sd0) begin
      tests_failed++;
      $display("FAIL reset mid-drain: busy=%b rd_en=%b valid=%b mul_a=%0d, expected all 0",
               bus.busy, bus.rd_en, bus.res_valid, bus.mul_a);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    run_checked("after reset", 5, 900, 901, $urandom);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.base_a    = '0;
    bus.base_b    = '0;
    bus.bias      = '0;
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_signs();
    test_zero_len_backpressure();
    test_addr_wrap();
    test_acc_wrap();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_dot_product_seq

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
- Sequencer that computes one signed int8 dot product plus a 32-bit bias per job.
- Fetches operand pairs from two operand buffers that have 1-cycle read latency.
- Streams each pair through one external registered int8 multiplier with 1-cycle latency, which returns 0 if either operand is 0.
- Accumulates the products and presents the result on a valid/ready port. Sits between the ViT tile scheduler and the multiplier/buffer datapath.

Parameters:
- ADDR_W, 10, operand buffer address width.
- LEN_W, 11, job length field width; maximum length 2^LEN_W-1.
- ACC_W, 32, accumulator and result width; must equal the multiplier product width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-high reset (despite the name).
- start  in  1  job request, sampled only in IDLE.
- len  in  LEN_W  number of element pairs, unsigned.
- base_a  in  ADDR_W  start address, buffer A.
- base_b  in  ADDR_W  start address, buffer B.
- bias  in  ACC_W  signed initial accumulator value.
- abort  in  1  synchronous job cancel.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  read strobe to both buffers.
- rd_addr_a  out  ADDR_W  buffer A address.
- rd_addr_b  out  ADDR_W  buffer B address.
- rd_data_a  in  8  signed, valid the cycle after rd_en.
- rd_data_b  in  8  signed, valid the cycle after rd_en.
- mul_a  out  8  signed multiplier operand A.
- mul_b  out  8  signed multiplier operand B.
- mul_p  in  ACC_W  signed multiplier product, valid 1 cycle after mul_a/mul_b.
- res_valid  out  1  result available.
- res_data  out  ACC_W  signed result.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset: all outputs 0, state IDLE. Internal address counter, issue counter, pipeline valid bits and accumulator are all cleared.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 and len>0: latch len/base_a/base_b, set acc=bias, go to FETCH.
  - start=1 and len=0: set acc=bias, go directly to DONE; no reads are issued.
- FETCH:
  - rd_en=1 every cycle.
  - Address i of the job is base+i on each port; addresses wrap modulo 2^ADDR_W.
  - After the len-th issue, go to DRAIN.
  - No stalls: exactly len consecutive rd_en cycles.
- Pipeline (per element, issue cycle k):
  - k: rd_addr driven.
  - k+1: rd_data is routed combinationally to mul_a/mul_b, qualified by valid stage v1.
  - k+2: mul_p is valid (stage v2); acc <= acc + mul_p on that clock edge.
  - Accumulation is two's-complement wrap modulo 2^ACC_W, with no saturation.
  - When v1=0, mul_a and mul_b are driven to 0.
- DRAIN: rd_en=0. Go to DONE on the cycle after the last v2 accumulate, so that acc is final.
- DONE:
  - res_valid=1 and res_data=acc, both held stable until res_ready=1.
  - The handshake completes on the edge where res_valid && res_ready; go to IDLE. res_valid falls the next cycle.
- Latency: for len=N, res_valid first rises N+3 cycles after the start edge.
- Back-to-back jobs:
  - start is ignored in all states except IDLE.
  - A start asserted on the handshake cycle is ignored; the earliest new job is accepted the cycle after IDLE is entered.
- abort:
  - In FETCH or DRAIN: go to IDLE next edge; clear the pipeline valid bits; no result is produced.
  - In DONE or IDLE: ignored (a pending result is still delivered).
  - abort and start together in IDLE: start wins.
- Reset mid-job: immediate return to IDLE with all outputs 0. Any in-flight buffer or multiplier data is discarded.
- len, base_a, base_b and bias are only sampled at job acceptance; later changes have no effect on the running job.

Test Plan:
- Basic job: len=4, A={1,2,3,4}, B={5,6,7,8}, bias=0. Required: res_data=70, res_valid at cycle 7 after start, rd_en high exactly 4 cycles at addresses base..base+3.
- Signs and zeros: len=3, A={-128,0,127}, B={-128,55,-1}, bias=-10. Required: res_data=16384+0-127-10=16247.
- Zero length and backpressure: len=0, bias=0x12345678. Required: no rd_en; res_valid held stable with the same value across 5 cycles of res_ready=0, then accepted, then IDLE.
- Address wrap: ADDR_W=10, base_a=1022, len=4. Required: rd_addr_a sequence 1022, 1023, 0, 1.
- Accumulator wrap: bias=0x7FFFFFF0, len=1, A=127, B=1. Required: res_data=0x8000006F.
- Abort and reset: abort asserted in the 3rd FETCH cycle of a len=8 job. Required: IDLE next cycle, no res_valid, and a following len=2 job returns the correct result. Separately, rst_n pulsed mid-DRAIN: all outputs 0 immediately.
